// File: rtl/uart_tx_fifo.sv
// UART transmitter with TX FIFO, runtime divisor, 5-8 data bits,
// optional parity, 1/2 stop bits, status register and TX-idle irq.
module uart_tx_fifo #(
  parameter int DEPTH     = 16,
  parameter int DIV_WIDTH = 16,
  parameter int DIV_RESET = 868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_addr,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        serialOut,
  output logic        irq
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP
  } state_e;

  state_e state_q, state_d;

  logic [7:0]    fifo_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  logic          full, empty, push, pop;

  logic          accept, is_wr, tx_wr, ack, ctrl_wr;
  logic [1:0]    sel;
  logic          ready_q;
  logic [31:0]   rdata_q, rdata_d;

  logic [DIV_WIDTH-1:0] div_q;
  logic [1:0]    par_q, bits_q;
  logic          stop2_q, irq_en_q;
  logic [31:0]   ctrl_rd, status, wmask, ctrl_nv;

  logic [DIV_WIDTH-1:0] dlat_q, bcnt_q;
  logic [2:0]    bit_q, nb_q;
  logic [7:0]    sh_q, head, dmask;
  logic          pen_q, pbit_q, s2_q;
  logic          tick, last_stop;

  logic          serial_q, serial_d;
  logic          irq_q, irq_d;
  logic          unused_ok;

  assign unused_ok = ^{mem_instr, mem_addr[31:4], mem_addr[1:0]};

  assign full   = cnt_q == CW'(DEPTH);
  assign empty  = cnt_q == '0;
  assign sel    = mem_addr[3:2];
  assign is_wr  = |mem_wstrb;
  assign accept = enable & mem_valid & ~ready_q;
  assign tx_wr  = accept & is_wr & (sel == 2'd0) & mem_wstrb[0];
  // a TXDATA write into a full FIFO waits here until a slot frees
  assign push    = tx_wr & ~full;
  assign ack     = accept & ~(tx_wr & full);
  assign ctrl_wr = accept & is_wr & (sel == 2'd2);

  assign wmask = {{8{mem_wstrb[3]}}, {8{mem_wstrb[2]}},
                  {8{mem_wstrb[1]}}, {8{mem_wstrb[0]}}};
  assign ctrl_nv = (ctrl_rd & ~wmask) | (mem_wdata & wmask);

  always_comb begin
    ctrl_rd = '0;
    ctrl_rd[DIV_WIDTH-1:0] = div_q;
    ctrl_rd[17:16] = par_q;
    ctrl_rd[18]    = stop2_q;
    ctrl_rd[19]    = irq_en_q;
    ctrl_rd[21:20] = bits_q;
  end

  always_comb begin
    status = '0;
    status[0]    = full;
    status[1]    = empty;
    status[2]    = state_q != S_IDLE;
    status[3]    = irq_q;
    status[15:8] = 8'(cnt_q);
  end

  always_comb begin
    rdata_d = '0;
    if (ack && !is_wr) begin
      unique case (sel)
        2'd1:    rdata_d = status;
        2'd2:    rdata_d = ctrl_rd;
        default: rdata_d = '0;
      endcase
    end
  end

  assign head      = fifo_q[rp_q];
  assign dmask     = 8'hFF >> (2'd3 - bits_q);
  assign tick      = bcnt_q == (dlat_q - DIV_WIDTH'(1));
  assign last_stop = ~s2_q | bit_q[0];
  assign pop = ~empty & ((state_q == S_IDLE) |
               ((state_q == S_STOP) & tick & last_stop));

  always_ff @(posedge clk) begin
    if (push) fifo_q[wp_q] <= mem_wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q     <= '0;
      rp_q     <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      rdata_q  <= '0;
      div_q    <= DIV_WIDTH'(DIV_RESET);
      par_q    <= 2'b00;
      bits_q   <= 2'd3;
      stop2_q  <= 1'b0;
      irq_en_q <= 1'b0;
      serial_q <= 1'b1;
      irq_q    <= 1'b0;
    end else begin
      ready_q  <= ack;
      rdata_q  <= rdata_d;
      serial_q <= serial_d;
      irq_q    <= irq_d;
      if (push) wp_q <= wp_q + AW'(1);
      if (pop)  rp_q <= rp_q + AW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (ctrl_wr) begin
        div_q    <= ctrl_nv[DIV_WIDTH-1:0];
        par_q    <= ctrl_nv[17:16];
        stop2_q  <= ctrl_nv[18];
        irq_en_q <= ctrl_nv[19];
        bits_q   <= ctrl_nv[21:20];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (pop) state_d = S_START;
      S_START: if (tick) state_d = S_DATA;
      S_DATA:  if (tick && bit_q == nb_q)
                 state_d = pen_q ? S_PAR : S_STOP;
      S_PAR:   if (tick) state_d = S_STOP;
      S_STOP:  if (tick && last_stop)
                 state_d = pop ? S_START : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    serial_d = 1'b1;
    irq_d    = irq_en_q & empty & (state_q == S_IDLE);
    unique case (state_q)
      S_START: serial_d = 1'b0;
      S_DATA:  serial_d = sh_q[0];
      S_PAR:   serial_d = pbit_q;
      default: serial_d = 1'b1;
    endcase
  end

  // frame config is captured at pop so CTRL writes only hit the next frame
  always_ff @(posedge clk) begin
    if (reset) begin
      dlat_q <= DIV_WIDTH'(1);
      bcnt_q <= '0;
      bit_q  <= '0;
      nb_q   <= 3'd7;
      sh_q   <= '0;
      pen_q  <= 1'b0;
      pbit_q <= 1'b0;
      s2_q   <= 1'b0;
    end else if (pop) begin
      dlat_q <= (div_q == '0) ? DIV_WIDTH'(1) : div_q;
      bcnt_q <= '0;
      bit_q  <= '0;
      nb_q   <= {1'b0, bits_q} + 3'd4;
      sh_q   <= head;
      pen_q  <= ^par_q;
      pbit_q <= (^(head & dmask)) ^ (par_q == 2'b10);
      s2_q   <= stop2_q;
    end else if (state_q != S_IDLE) begin
      bcnt_q <= tick ? '0 : bcnt_q + DIV_WIDTH'(1);
      if (tick) begin
        if (state_q == S_DATA) begin
          sh_q  <= sh_q >> 1;
          bit_q <= (bit_q == nb_q) ? '0 : bit_q + 3'd1;
        end else if (state_q == S_STOP) begin
          bit_q <= bit_q + 3'd1;
        end else begin
          bit_q <= '0;
        end
      end
    end
  end

  assign mem_ready = ready_q;
  assign mem_rdata = rdata_q;
  assign serialOut = serial_q;
  assign irq       = irq_q;

endmodule
